// File: rtl/dmem_bytelane_if.sv
// Data-memory bus between the core and dmem_bytelane.
// The core drives the request fields; the memory returns load data, the fault
// flag and sweep readiness.
interface dmem_bytelane_if;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        fault;
    logic        ready;

    modport master (
        output we, funct3, addr, wd,
        input  rd, fault, ready
    );

    modport slave (
        input  we, funct3, addr, wd,
        output rd, fault, ready
    );
endinterface

// File: rtl/dmem_bytelane.sv
// Byte-addressed, little-endian data memory for the single-cycle RV32I core.
// Supports SB/SH/SW and LB/LH/LW/LBU/LHU with lane-masked writes and
// sign/zero-extended loads. Misaligned, out-of-range and illegal accesses
// raise fault. After reset, a sweep FSM zeroes the array before ready rises.
module dmem_bytelane #(
    parameter int unsigned DEPTH = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    dmem_bytelane_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            ready_q, ready_d;

    // Storage is deliberately not reset; the sweep defines its contents.
    logic [3:0][7:0] mem_q [DEPTH];

    logic            in_run;
    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            sz_byte, sz_half, sz_word;
    logic            ld_unsigned, illegal_f3;
    logic            misaligned, out_of_range, access_fault;

    logic [3:0][7:0] rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     ld_ext;

    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [3:0]      wr_mask;
    logic [3:0][7:0] wr_data;

    assign in_run   = (state_q == RUN);
    assign word_idx = bus.addr[AW+1:2];
    assign lane     = bus.addr[1:0];

    // Decode funct3 into access size, signedness and legality.
    always_comb begin
        sz_byte     = 1'b0;
        sz_half     = 1'b0;
        sz_word     = 1'b0;
        ld_unsigned = 1'b0;
        illegal_f3  = 1'b0;
        case (bus.funct3)
            3'b000:  sz_byte = 1'b1;
            3'b001:  sz_half = 1'b1;
            3'b010:  sz_word = 1'b1;
            3'b100: begin
                sz_byte     = 1'b1;
                ld_unsigned = 1'b1;
            end
            3'b101: begin
                sz_half     = 1'b1;
                ld_unsigned = 1'b1;
            end
            default: illegal_f3 = 1'b1;
        endcase
    end

    // Fault classification; unsigned sizes have no store form.
    always_comb begin
        misaligned   = (sz_half & bus.addr[0]) | (sz_word & (bus.addr[1:0] != 2'b00));
        out_of_range = |bus.addr[31:AW+2];
        access_fault = illegal_f3 | (bus.we & ld_unsigned) | misaligned | out_of_range;
    end

    // Load path: pick the addressed byte/half, shift to bit 0, extend.
    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[lane];
        rd_half = bus.addr[1] ? {rd_word[3], rd_word[2]} : {rd_word[1], rd_word[0]};
        if (sz_byte) begin
            ld_ext = {{24{~ld_unsigned & rd_byte[7]}}, rd_byte};
        end else if (sz_half) begin
            ld_ext = {{16{~ld_unsigned & rd_half[15]}}, rd_half};
        end else begin
            ld_ext = rd_word;
        end
    end

    assign bus.rd    = (in_run && !access_fault) ? ld_ext : '0;
    assign bus.fault = in_run & access_fault;
    assign bus.ready = ready_q;

    // Write port: the sweep owns it in CLEAR, the bus owns it in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = word_idx;
        wr_mask = '0;
        wr_data = bus.wd;
        if (!in_run) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx_q;
            wr_mask = '1;
            wr_data = '0;
        end else begin
            wr_en = bus.we & ~access_fault;
            if (sz_byte) begin
                wr_mask = 4'b0001 << lane;
                wr_data = {4{bus.wd[7:0]}};
            end else if (sz_half) begin
                wr_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.wd[15:0]}};
            end else begin
                wr_mask = '1;
                wr_data = bus.wd;
            end
        end
    end

    // Lane-masked array update; unselected lanes hold their value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem_q[wr_idx][b] <= wr_data[b];
                end
            end
        end
    end

    // Sweep sequencing: walk clr_idx to DEPTH-1, then enter RUN for good.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        if (state_q == CLEAR) begin
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
                ready_d = 1'b1;
            end else begin
                clr_idx_d = clr_idx_q + AW'(1);
            end
        end
    end

    // Control state with asynchronous restart of the sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised, byte-addressed data memory for the single-cycle RISC-V core, replacing the word-indexed 32-entry data memory. It supports the RV32I load/store sizes (SB/SH/SW, LB/LH/LW/LBU/LHU) with per-lane writes and sign or zero extension. It reports misaligned, out-of-range and illegal-size accesses. Instead of clearing every entry asynchronously at reset, it clears the storage array with a post-reset sweep state machine and flags readiness to the core.

## Interface

- DEPTH, 64, number of 32-bit words; power of two, 2..4096.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  store request, sampled on rising clk.
- funct3  in  3  access size and sign; the RV32I load/store funct3 field.
- addr  in  32  byte address.
- wd  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- rd  out  32  load data, combinational, extended per funct3.
- fault  out  1  combinational; high on any misaligned, out-of-range or illegal access.
- ready  out  1  high once the clear sweep is complete.

## Operation

- Word index is addr[AW+1:2], where AW = log2(DEPTH). The byte lane is addr[1:0]. Storage is little-endian.
- Legal funct3 values:
  - 000 is byte (signed load).
  - 001 is half (signed load).
  - 010 is word.
  - 100 is byte unsigned.
  - 101 is half unsigned.
- The following raise fault:
  - funct3 011, 110 or 111.
  - funct3 100 or 101 while we=1.
- Misaligned accesses raise fault:
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
- Out of range raises fault: addr ≥ DEPTH*4. There is no aliasing.
- When fault=1, no write occurs and rd is 0. fault is evaluated for we=0 as well, since loads must trap too.
- Stores are lane-masked:
  - SB writes lane addr[1:0] with wd[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wd[15:0].
  - SW writes all four lanes.
  - Unselected lanes keep their old value.
- Loads:
  - The selected byte or half is taken from the addressed word and shifted to bit 0.
  - LB and LH sign-extend from bit 7 or bit 15; LBU and LHU zero-extend.
- The storage array is not reset by reset_n. Contents become defined only through the sweep.
- The FSM has two states:
  - CLEAR: on each rising edge, writes 32'h0 to mem[clr_idx] and increments clr_idx. When clr_idx = DEPTH-1, that last write occurs and the next state is RUN. In CLEAR, `we` is ignored, rd = 0 and fault = 0.
  - RUN: normal access. There is no exit except reset.
- clr_idx is AW bits wide and does not wrap within a sweep.

## Timing

- Reset values, asynchronous on reset_n=0:
  - state = CLEAR, clr_idx = 0, ready = 0.
  - rd = 0 and fault = 0 while in CLEAR.
- ready rises on the DEPTH-th rising edge after reset_n deasserts. With the default DEPTH, that is 64 edges.
- Reset asserted mid-sweep: the sweep aborts immediately and restarts from index 0 after release. ready stays 0 throughout.
- Reset in RUN: ready drops asynchronously and the full sweep reruns.
- Write latency is one edge: data stored at edge N is visible on rd combinationally after edge N.
- A load and store to the same word in the same cycle returns the pre-write contents.
- rd and fault follow addr, funct3 and array contents with no cycle delay.

## Test plan

- Sweep: reset_n low for 3 cycles, then release. Required: ready=0 for exactly 64 edges, then 1. LW of 0x0, 0x7C and 0xFC each returns 0.
- Store/load extension: SW 0x800000F0 at 0x10. Required:
  - LW 0x10 → 0x800000F0.
  - LB 0x10 → 0xFFFFFFF0.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF8000.
  - LHU 0x12 → 0x00008000.
- Lane masking: SW 0x11223344 at 0x20, then SB wd=0x000000AB at 0x21. Required: LW 0x20 → 0x1122AB44. Then SH wd=0x0000BEEF at 0x22; required: LW 0x20 → 0xBEEFAB44.
- Faults: each of the following gives fault=1, rd=0, and word 0x20 unchanged at 0xBEEFAB44:
  - SW at 0x22.
  - SH at 0x21.
  - funct3=011 store at 0x20.
  - funct3=100 with we=1.
- Range: DEPTH=64, LW or SW at 0x100 → fault=1 and no write. LW 0xFC after SW there → data returned, fault=0.
- Reset mid-sweep: assert reset_n at edge 30 of the sweep, release 2 cycles later. Also drive we=1 with SW 0xDEADBEEF at 0x0 during the sweep. Required: ready rises 64 edges after the second release, and LW 0x0 → 0.
